axi_slave_write: RTL
====================

Name: axi_slave_write

Overview:
- AXI4 write-channel slave that sits directly downstream of the CPU-side write master, across the interconnect.
- Accepts AW/W/B traffic and converts it into a single-port, byte-enabled SRAM write interface.
- Supports single-beat and INCR bursts up to 16 beats.
- Arbitrates the shared memory port against the companion read-side slave through a busy handshake.

Parameters:
- ID_W, 8, width of AWID/BID (slave-side ID, master ID plus interconnect prefix)
- ADDR_W, 32, AXI address width
- DATA_W, 32, data width; one beat equals one word
- LEN_W, 4, AWLEN width (1-16 beats)
- MEM_AW, 14, SRAM word-address width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- AWID  in  ID_W  write ID
- AWADDR  in  ADDR_W  byte address of first beat
- AWLEN  in  LEN_W  beats minus 1
- AWSIZE  in  3  must be 3'b010; otherwise ignored
- AWBURST  in  2  ignored; address always increments
- AWVALID  in  1  address valid
- AWREADY  out  1  address ready
- WDATA  in  DATA_W  write data
- WSTRB  in  DATA_W/8  byte strobes
- WLAST  in  1  last beat
- WVALID  in  1  data valid
- WREADY  out  1  data ready
- BID  out  ID_W  response ID
- BRESP  out  2  2'b00 OKAY / 2'b10 SLVERR
- BVALID  out  1  response valid
- BREADY  in  1  response ready
- rd_busy  in  1  read-side slave owns the memory port
- wr_busy  out  1  this block owns the memory port (state != IDLE)
- mem_en  out  1  SRAM access strobe
- mem_web  out  DATA_W/8  active-high byte write enables
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  DATA_W  SRAM write data

Behaviour:
- Reset is synchronous on ACLK when ARESETn=0:
  - state=IDLE
  - BVALID=0, BRESP=0, BID=0, WREADY=0
  - mem_en=0, mem_web=0, mem_addr=0
  - beat counter=0, error flag=0
- Reset mid-burst drops the burst silently: no B response, no further memory writes.
- States: IDLE, DATA, RESP.
- IDLE:
  - AWREADY = !rd_busy (combinational); WREADY=0.
  - On AWVALID&&AWREADY at cycle T: latch AWID, AWADDR[MEM_AW+1:2], AWLEN; clear counter and error flag; go to DATA at T+1.
  - rd_busy and AWVALID together: AWREADY=0 and the request waits. The read side has priority when both start in the same cycle; the read side sees wr_busy only from T+1.
- DATA:
  - AWREADY=0, WREADY=1.
  - Each beat with WVALID&&WREADY:
    - mem_en=1, mem_web=WSTRB, mem_wdata=WDATA, mem_addr=latched word address (same cycle, combinational).
    - Word address then increments by 1, wrapping modulo 2^MEM_AW.
    - Counter increments.
  - Beats after counter exceeds AWLEN: memory write suppressed (mem_en=0), error flag set.
  - WLAST with counter != AWLEN: error flag set.
  - WLAST accepted at cycle U: go to RESP at U+1.
  - A burst with no WLAST stays in DATA indefinitely.
- RESP:
  - BVALID=1, BID=latched ID, BRESP = error ? 2'b10 : 2'b00; WREADY=0.
  - BID/BRESP held stable until BVALID&&BREADY at cycle V; IDLE at V+1, AWREADY may rise at V+1.
- Minimum single-beat turnaround: AW at T, W at T+1, B at T+2, next AW at T+3.
- mem_en/mem_web are 0 whenever no W handshake occurs.
- AWVALID and WVALID arriving together in IDLE: only AW is accepted; W is accepted from T+1.

Decomposition:
- Shared package axi_slave_pkg:
  - state enum {IDLE, DATA, RESP}
  - RESP_OKAY, RESP_SLVERR
  - SIZE_WORD=3'b010
- The AXI width macros remain in the common AXI define header.
- No sub-module; beat counter and address incrementer live inline.

Test Plan:
- Single write: AWID=8'h11, AWADDR=32'h0000_0010, AWLEN=0; W data 32'hDEADBEEF, WSTRB=4'hF, WLAST=1 -> mem_addr=4, mem_web=4'hF at T+1; BVALID at T+2 with BID=8'h11, BRESP=0.
- 4-beat burst from AWADDR=32'h0000_0100, strobes F,3,C,0 -> mem_addr 64,65,66,67 with matching mem_web; one B with OKAY.
- Early WLAST on beat 2 of AWLEN=3 -> 2 memory writes, BRESP=2'b10. Missing WLAST: 5th beat with WLAST -> no 5th memory write, BRESP=2'b10.
- Backpressure: BREADY low for 5 cycles -> BVALID and BID stable all 5 cycles, AWREADY stays 0 until the cycle after the B handshake.
- Arbitration: rd_busy=1 with AWVALID=1 -> AWREADY=0 until rd_busy drops; then accepted same cycle.
- Wrap/reset: AWADDR word 2^14-1, AWLEN=1 -> mem_addr 16383 then 0. ARESETn low during DATA -> IDLE next cycle, BVALID stays 0, mem_en=0.

Source files
------------

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI write slave and its read-side companion.
package axi_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

endpackage

// File: rtl/axi_slave_write_if.sv
// AXI4 write-channel bundle (AW, W, B) with master and slave views.
interface axi_slave_write_if #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
);

    logic [ID_W-1:0]     AWID;
    logic [ADDR_W-1:0]   AWADDR;
    logic [LEN_W-1:0]    AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;
    logic [ID_W-1:0]     BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

endinterface

// File: rtl/axi_slave_write.sv
// AXI4 write slave: turns AW/W/B bursts (INCR, up to 16 beats) into byte-enabled
// single-port SRAM writes, sharing the memory port with the read slave via busy flags.
//
// state | meaning
// IDLE  | memory port free; accept AW when the read side is not busy
// DATA  | own the memory port; one SRAM write per accepted W beat
// RESP  | present B response until BREADY
module axi_slave_write
    import axi_slave_pkg::*;
#(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int MEM_AW = 14
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    axi_slave_write_if.slave    s_axi,
    input  logic                rd_busy,
    output logic                wr_busy,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_web,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata
);

    state_t              r_state, w_state_nxt;
    logic [ID_W-1:0]     r_id, w_id_nxt;
    logic [MEM_AW-1:0]   r_addr, w_addr_nxt;
    logic [LEN_W-1:0]    r_len, w_len_nxt;
    logic [LEN_W:0]      r_cnt, w_cnt_nxt;
    logic                r_err, w_err_nxt;

    logic                w_awready;
    logic                w_wready;
    logic                w_bvalid;
    logic                w_mem_en;
    logic [DATA_W/8-1:0] w_mem_web;
    logic                w_in_range;

    // Size and burst type are not acted on; the address always steps one word per beat.
    logic w_unused;
    assign w_unused = &{1'b0, (s_axi.AWSIZE == SIZE_WORD), s_axi.AWBURST,
                        s_axi.AWADDR[ADDR_W-1:MEM_AW+2], s_axi.AWADDR[1:0]};

    assign w_in_range = (r_cnt <= {1'b0, r_len});

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_addr_nxt  = r_addr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_awready   = 1'b0;
        w_wready    = 1'b0;
        w_bvalid    = 1'b0;
        w_mem_en    = 1'b0;
        w_mem_web   = '0;

        unique case (r_state)
            IDLE: begin
                w_awready = !rd_busy;
                if (s_axi.AWVALID && w_awready) begin
                    w_id_nxt    = s_axi.AWID;
                    w_addr_nxt  = s_axi.AWADDR[MEM_AW+1:2];
                    w_len_nxt   = s_axi.AWLEN;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_wready = 1'b1;
                if (s_axi.WVALID) begin
                    w_mem_en   = w_in_range;
                    w_mem_web  = w_in_range ? s_axi.WSTRB : '0;
                    w_addr_nxt = r_addr + 1'b1;
                    // Saturate so a runaway burst never wraps back into range.
                    w_cnt_nxt  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
                    if (!w_in_range) begin
                        w_err_nxt = 1'b1;
                    end
                    if (s_axi.WLAST) begin
                        if (r_cnt != {1'b0, r_len}) begin
                            w_err_nxt = 1'b1;
                        end
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                w_bvalid = 1'b1;
                if (s_axi.BREADY) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Nothing handshakes or writes while reset is held.
        if (!ARESETn) begin
            w_awready = 1'b0;
            w_wready  = 1'b0;
            w_bvalid  = 1'b0;
            w_mem_en  = 1'b0;
            w_mem_web = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_id    <= w_id_nxt;
            r_addr  <= w_addr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign s_axi.AWREADY = w_awready;
    assign s_axi.WREADY  = w_wready;
    assign s_axi.BVALID  = w_bvalid;
    assign s_axi.BID     = r_id;
    assign s_axi.BRESP   = (w_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;

    assign wr_busy   = (r_state != IDLE);
    assign mem_en    = w_mem_en;
    assign mem_web   = w_mem_web;
    assign mem_addr  = r_addr;
    assign mem_wdata = s_axi.WDATA;

endmodule
